// File: rtl/sound_pkg.sv
// Shared definitions for the game sound interface: frequency codes and
// the tone player state encoding.
package sound_pkg;

  localparam int FREQ_W = 10;

  typedef logic [FREQ_W-1:0] freq_t;

  // Half-periods in 1 us ticks: about 1 kHz for a loss, 2.6 kHz for a win.
  localparam freq_t LOSE_FREQ = 10'd500;
  localparam freq_t WIN_FREQ  = 10'd190;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } tone_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running timebase divider: tick is high for one clock every CLK_DIV
// clocks, restarting from zero whenever clear is asserted.
module tick_prescaler #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] pre_cnt_r;

  // Prescaler count, wrapped at its terminal value or on clear.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pre_cnt_r <= '0;
    end else if (clear || (pre_cnt_r == LAST)) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + CNT_W'(1);
    end
  end

  assign tick = (pre_cnt_r == LAST);

endmodule

// File: rtl/frog_tone_player.sv
// Latches a short sound request from the game FSM and plays it as a
// fixed-length square wave (or silence when the code is 0) on audio_out.
module frog_tone_player
  import sound_pkg::*;
#(
  parameter int CLK_DIV        = 25,
  parameter int DURATION_TICKS = 250000,
  parameter int FREQ_W         = 10
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [FREQ_W-1:0] sound_freq,
  input  logic              enable_sound,
  output logic              audio_out,
  output logic              busy,
  output logic              done
);

  localparam int DUR_W = (DURATION_TICKS > 1) ? $clog2(DURATION_TICKS) : 1;
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DURATION_TICKS - 1);

  tone_state_t       state_r;
  logic [FREQ_W-1:0] freq_r;
  logic [FREQ_W-1:0] half_cnt_r;
  logic [DUR_W-1:0]  dur_cnt_r;
  logic              enable_d_r;
  logic              audio_r;
  logic              busy_r;
  logic              done_r;
  logic              trigger_s;
  logic              tick_s;

  assign trigger_s = enable_sound & ~enable_d_r;

  // A trigger restarts the timebase so the first tick lands CLK_DIV clocks later.
  tick_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .resetN(resetN),
    .clear (trigger_s),
    .tick  (tick_s)
  );

  // Request edge detector and tone sequencer with registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r    <= IDLE;
      freq_r     <= '0;
      half_cnt_r <= '0;
      dur_cnt_r  <= '0;
      enable_d_r <= 1'b0;
      audio_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      enable_d_r <= enable_sound;
      done_r     <= 1'b0;
      // A trigger reloads from either state, so it outranks expiry and toggling.
      if (trigger_s) begin
        state_r    <= PLAY;
        freq_r     <= sound_freq;
        half_cnt_r <= '0;
        dur_cnt_r  <= '0;
        audio_r    <= 1'b0;
        busy_r     <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            audio_r <= 1'b0;
            busy_r  <= 1'b0;
          end
          PLAY: begin
            if (tick_s) begin
              if (dur_cnt_r == DUR_LAST) begin
                state_r    <= IDLE;
                half_cnt_r <= '0;
                dur_cnt_r  <= '0;
                audio_r    <= 1'b0;
                busy_r     <= 1'b0;
                done_r     <= 1'b1;
              end else begin
                dur_cnt_r <= dur_cnt_r + DUR_W'(1);
                if (freq_r != '0) begin
                  if (half_cnt_r == (freq_r - FREQ_W'(1))) begin
                    half_cnt_r <= '0;
                    audio_r    <= ~audio_r;
                  end else begin
                    half_cnt_r <= half_cnt_r + FREQ_W'(1);
                  end
                end else begin
                  half_cnt_r <= '0;
                end
              end
            end else begin
              busy_r <= 1'b1;
            end
          end
          default: begin
            state_r <= IDLE;
            audio_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign audio_out = audio_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_frog_tone_player.sv
// Scoreboard bench for frog_tone_player: a timing model derived from the
// trigger-relative edge numbering predicts {busy, audio_out, done} per clock.
module tb_frog_tone_player;
  import sound_pkg::*;

  localparam int C = 4;
  localparam int D = 16;

  logic       clk;
  logic       resetN;
  logic [9:0] sound_freq;
  logic       enable_sound;
  logic       audio_out;
  logic       busy;
  logic       done;

  int checks;
  int failures;
  int cyc;

  logic [2:0] exp_q[$];

  // Reference model state
  int m_active;
  int m_k;
  int m_freq;
  int m_en_d;

  frog_tone_player #(
    .CLK_DIV(C),
    .DURATION_TICKS(D),
    .FREQ_W(10)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .sound_freq(sound_freq),
    .enable_sound(enable_sound),
    .audio_out(audio_out),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 0;
    m_k = 0;
    m_freq = 0;
    m_en_d = 0;
    exp_q.delete();
  endtask

  // Drive one clock of stimulus, predict the outputs after the next rising
  // edge, push the prediction and return just after that edge.
  task automatic drive(input logic en, input logic [9:0] f);
    logic [2:0] e;
    int trig;
    int done_e;
    int audio_e;
    @(negedge clk);
    enable_sound = en;
    sound_freq = f;
    trig = (en && (m_en_d == 0)) ? 1 : 0;
    m_en_d = en ? 1 : 0;
    done_e = 0;
    if (trig != 0) begin
      m_active = 1;
      m_k = 0;
      m_freq = int'(f);
    end else if (m_active != 0) begin
      m_k++;
      if (m_k == D * C) begin
        m_active = 0;
        done_e = 1;
      end
    end
    audio_e = 0;
    if (m_active != 0 && m_freq != 0)
      audio_e = ((m_k / (m_freq * C)) % 2);
    e = {m_active[0], audio_e[0], done_e[0]};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [2:0] e;
    resetN = 1'b0;
    enable_sound = 1'b0;
    sound_freq = 10'd0;
    model_reset();
    #12;
    checks++;
    if ({busy, audio_out, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=000", {busy, audio_out, done});
    end
    @(posedge clk);
    #2 resetN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 10'd0);
      e = exp_q.pop_front();
      checks++;
      if ({busy, audio_out, done} !== e) begin
        failures++;
        $display("FAIL idle cyc=%0d got=%b exp=%b", i, {busy, audio_out, done}, e);
      end
    end
  endtask

  task automatic test_tone(input string name, input logic [9:0] f, input int idle_after);
    logic [2:0] e;
    int dones;
    dones = 0;
    for (int i = 0; i <= idle_after; i++) begin
      drive(i == 0, f);
      e = exp_q.pop_front();
      dones += int'(done);
      checks++;
      if ({busy, audio_out, done} !== e) begin
        failures++;
        $display("FAIL %s E%0d got=%b exp=%b", name, i, {busy, audio_out, done}, e);
      end
    end
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL %s_done_count got=%0d exp=1", name, dones);
    end
  endtask

  task automatic test_held();
    logic [2:0] e;
    int dones;
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      drive(1'b1, (i < 30) ? 10'd1 : 10'd3);
      e = exp_q.pop_front();
      dones += int'(done);
      checks++;
      if ({busy, audio_out, done} !== e) begin
        failures++;
        $display("FAIL held E%0d got=%b exp=%b", i, {busy, audio_out, done}, e);
      end
    end
    drive(1'b0, 10'd0);
    e = exp_q.pop_front();
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL held_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_retrigger();
    logic [2:0] e;
    int first_done;
    first_done = -1;
    for (int i = 0; i < 100; i++) begin
      drive((i == 0) || (i == 20), (i < 20) ? 10'd2 : 10'd1);
      e = exp_q.pop_front();
      if (done && first_done < 0) first_done = i;
      checks++;
      if ({busy, audio_out, done} !== e) begin
        failures++;
        $display("FAIL retrig E%0d got=%b exp=%b", i, {busy, audio_out, done}, e);
      end
    end
    checks++;
    if (first_done != 84) begin
      failures++;
      $display("FAIL retrig_done_edge got=%0d exp=84", first_done);
    end
  endtask

  // Trigger landing on the expiry edge: no done, fresh tone.
  task automatic test_back_to_back();
    logic [2:0] e;
    for (int i = 0; i < 140; i++) begin
      drive((i == 0) || (i == 64), (i < 64) ? 10'd2 : 10'd3);
      e = exp_q.pop_front();
      checks++;
      if ({busy, audio_out, done} !== e) begin
        failures++;
        $display("FAIL b2b E%0d got=%b exp=%b", i, {busy, audio_out, done}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    for (int i = 0; i < 30; i++) begin
      drive(i == 0, 10'd2);
      e = exp_q.pop_front();
      checks++;
      if ({busy, audio_out, done} !== e) begin
        failures++;
        $display("FAIL rmid E%0d got=%b exp=%b", i, {busy, audio_out, done}, e);
      end
    end
    #2 resetN = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({busy, audio_out, done} !== 3'b000) begin
      failures++;
      $display("FAIL rmid_async got=%b exp=000", {busy, audio_out, done});
    end
    @(posedge clk);
    #2 resetN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 10'd2);
      e = exp_q.pop_front();
      checks++;
      if ({busy, audio_out, done} !== e) begin
        failures++;
        $display("FAIL rmid_after E%0d got=%b exp=%b", i, {busy, audio_out, done}, e);
      end
    end
    // enable already high across reset release counts as a trigger
    @(negedge clk);
    resetN = 1'b0;
    enable_sound = 1'b1;
    sound_freq = 10'd1;
    model_reset();
    @(posedge clk);
    #2 resetN = 1'b1;
    for (int i = 0; i < 70; i++) begin
      drive(1'b1, 10'd1);
      e = exp_q.pop_front();
      checks++;
      if ({busy, audio_out, done} !== e) begin
        failures++;
        $display("FAIL rel_high E%0d got=%b exp=%b", i, {busy, audio_out, done}, e);
      end
    end
    drive(1'b0, 10'd0);
    e = exp_q.pop_front();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    test_reset();
    test_tone("freq2", 10'd2, 70);
    test_tone("rest", 10'd0, 70);
    test_tone("win", WIN_FREQ, 70);
    test_held();
    test_retrigger();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
